addsub64: RTL and testbench

//  - Two's-complement adder/subtractor with ALU status flags, used in the datapath for PC+4

---
 rtl/addsub64_if.sv | 41 ++++
 rtl/addsub64.sv | 157 +++++++++++++++
 tb/tb_addsub64.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/addsub64_if.sv
// addsub64_if
//   Bundles the operand/result signals of the addsub64 adder/subtractor.
//   Parameter:
//     WIDTH      operand/result width in bits
//   Signals:
//     A, B       operands
//     M          mode: 0 = add, 1 = subtract
//     ovf_clr    synchronous clear of ovf_sticky
//     S          result, modulo 2^WIDTH
//     cout       carry out of MSB (subtract: 1 = no borrow)
//     ovf        signed overflow of the current result
//     zero       S == 0
//     neg        S[WIDTH-1]
//     ovf_sticky latched OR of ovf since last reset/clear
//   Modports:
//     master     drives operands, observes results (datapath / bench side)
//     slave      the adder itself
interface addsub64_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             M;
    logic             ovf_clr;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             ovf_sticky;

    modport master (
        output A, B, M, ovf_clr,
        input  S, cout, ovf, zero, neg, ovf_sticky
    );

    modport slave (
        input  A, B, M, ovf_clr,
        output S, cout, ovf, zero, neg, ovf_sticky
    );
endinterface

// File: rtl/addsub64.sv
// addsub64
//   Two's-complement adder/subtractor with ALU status flags. Used for PC+4,
//   branch-target adds and ALU add/sub.
//   S = A + (B ^ {WIDTH{M}}) + M, built from 4-bit carry-lookahead groups
//   whose group carries ripple from one group to the next.
//   Parameter:
//     WIDTH   operand/result width (>= 4, multiple of 4)
//   Ports:
//     clk     rising-edge clock
//     reset   asynchronous, active-high reset
//     bus     addsub64_if.slave: A, B, M, ovf_clr in; S, cout, ovf, zero,
//             neg, ovf_sticky out
//   Build option:
//     ADDSUB64_OUT_REG_EN  when defined, S/cout/ovf/zero/neg are registered
//                          (latency 1, reset to 0 except zero which resets
//                          to 1); when undefined they are combinational.
//                          ovf_sticky always samples the ovf seen at the
//                          output.
module addsub64 #(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    addsub64_if.slave   bus
);

    localparam int NGRP = WIDTH / 4;

    // ------------------------------------------------------------------
    // Combinational core
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_x;      // B conditionally inverted for subtract
    logic [WIDTH-1:0] gen;      // per-bit generate
    logic [WIDTH-1:0] prop;     // per-bit propagate
    logic [WIDTH:0]   carry;    // carry[i] = carry into bit i
    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic             sum_ovf;
    logic             sum_zero;
    logic             sum_neg;

    always_comb begin
        logic [3:0] g4;
        logic [3:0] p4;
        logic       cin;
        logic       grp_g;
        logic       grp_p;

        b_x   = bus.B ^ {WIDTH{bus.M}};
        gen   = bus.A & b_x;
        prop  = bus.A ^ b_x;
        carry = '0;
        // M doubles as the carry-in, completing the two's-complement negate.
        carry[0] = bus.M;

        for (int grp = 0; grp < NGRP; grp++) begin
            g4  = gen[grp*4 +: 4];
            p4  = prop[grp*4 +: 4];
            cin = carry[grp*4];

            // Internal carries of the group, all computed directly from the
            // group carry-in (lookahead inside the group).
            carry[grp*4 + 1] = g4[0] | (p4[0] & cin);
            carry[grp*4 + 2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cin);
            carry[grp*4 + 3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                             | (p4[2] & p4[1] & p4[0] & cin);

            // Group generate/propagate; the group carry-out ripples onward.
            grp_g = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                  | (p4[3] & p4[2] & p4[1] & g4[0]);
            grp_p = &p4;
            carry[grp*4 + 4] = grp_g | (grp_p & cin);
        end

        sum      = prop ^ carry[WIDTH-1:0];
        sum_cout = carry[WIDTH];
        // Signed overflow: carry into the MSB disagrees with carry out of it.
        sum_ovf  = carry[WIDTH] ^ carry[WIDTH-1];
        sum_zero = ~|sum;
        sum_neg  = sum[WIDTH-1];
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic out_ovf;   // ovf as seen on the output port

`ifdef ADDSUB64_OUT_REG_EN
    logic [WIDTH-1:0] s_q,    s_d;
    logic             cout_q, cout_d;
    logic             ovf_q,  ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q,  neg_d;

    always_comb begin
        s_d    = sum;
        cout_d = sum_cout;
        ovf_d  = sum_ovf;
        zero_d = sum_zero;
        neg_d  = sum_neg;
    end

    // zero resets to 1 so the flags agree with the reset value S = 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign out_ovf  = ovf_q;
`else
    assign bus.S    = sum;
    assign bus.cout = sum_cout;
    assign bus.ovf  = sum_ovf;
    assign bus.zero = sum_zero;
    assign bus.neg  = sum_neg;
    assign out_ovf  = sum_ovf;
`endif

    // ------------------------------------------------------------------
    // Sticky overflow; clear wins over a simultaneous overflow.
    // ------------------------------------------------------------------
    logic ovf_sticky_q, ovf_sticky_d;

    always_comb begin
        ovf_sticky_d = ovf_sticky_q | out_ovf;
        if (bus.ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign bus.ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_addsub64.sv
// tb_addsub64
//   Self-checking bench for addsub64 (either build of ADDSUB64_OUT_REG_EN).
//   Directed corner cases followed by random operations, compared against an
//   arithmetic reference model (wide integer add/sub and signed range test).
module tb_addsub64;

    localparam int W = 64;

    logic clk;
    logic reset;

    addsub64_if #(.WIDTH(W)) bus ();

    addsub64 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int pass_cnt = 0;
    int total_cnt = 0;

    // Model of what the output ports should show right now.
    logic [W-1:0] exp_s;
    logic         exp_cout, exp_ovf, exp_zero, exp_neg, exp_sticky;

    // ---------------- reference model ----------------
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic m,
                             output logic [W-1:0] s, output logic co,
                             output logic ov, output logic z, output logic n);
        logic [W:0]          full;
        logic signed [W+1:0] exact;
        logic signed [W+1:0] sa, sb, ss;
        full = {1'b0, a} + {1'b0, (m ? ~b : b)} + {{W{1'b0}}, m};
        s  = full[W-1:0];
        co = full[W];
        sa = $signed({a[W-1], a[W-1], a});
        sb = $signed({b[W-1], b[W-1], b});
        exact = m ? (sa - sb) : (sa + sb);
        ss = $signed({s[W-1], s[W-1], s});
        ov = (exact != ss);
        z  = (s == '0);
        n  = s[W-1];
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".S"},    bus.S, exp_s);
        check({tag, ".cout"}, {{(W-1){1'b0}}, bus.cout}, {{(W-1){1'b0}}, exp_cout});
        check({tag, ".ovf"},  {{(W-1){1'b0}}, bus.ovf},  {{(W-1){1'b0}}, exp_ovf});
        check({tag, ".zero"}, {{(W-1){1'b0}}, bus.zero}, {{(W-1){1'b0}}, exp_zero});
        check({tag, ".neg"},  {{(W-1){1'b0}}, bus.neg},  {{(W-1){1'b0}}, exp_neg});
    endtask

    task automatic check_sticky(input string tag);
        check({tag, ".sticky"}, {{(W-1){1'b0}}, bus.ovf_sticky},
              {{(W-1){1'b0}}, exp_sticky});
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: applies one operation, checks the
    // outputs at the point they are defined, then returns at the next
    // falling edge.
    task automatic step(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic m, input logic clr);
        logic [W-1:0] r_s;
        logic         r_co, r_ov, r_z, r_n;
        logic         ovf_before_edge;
        bus.A = a;
        bus.B = b;
        bus.M = m;
        bus.ovf_clr = clr;
        ref_model(a, b, m, r_s, r_co, r_ov, r_z, r_n);
`ifndef ADDSUB64_OUT_REG_EN
        #1;
        exp_s = r_s; exp_cout = r_co; exp_ovf = r_ov; exp_zero = r_z; exp_neg = r_n;
        check_outputs({tag, ".comb"});
`endif
        ovf_before_edge = exp_ovf;
        @(posedge clk);
        exp_sticky = clr ? 1'b0 : (exp_sticky | ovf_before_edge);
`ifdef ADDSUB64_OUT_REG_EN
        exp_s = r_s; exp_cout = r_co; exp_ovf = r_ov; exp_zero = r_z; exp_neg = r_n;
`endif
        #1;
        check_outputs({tag, ".edge"});
        check_sticky(tag);
        @(negedge clk);
    endtask

    task automatic reset_model();
        exp_sticky = 1'b0;
`ifdef ADDSUB64_OUT_REG_EN
        exp_s = '0; exp_cout = 1'b0; exp_ovf = 1'b0; exp_zero = 1'b1; exp_neg = 1'b0;
`else
        ref_model(bus.A, bus.B, bus.M, exp_s, exp_cout, exp_ovf, exp_zero, exp_neg);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra, rb;
        logic         rm, rc;

        reset = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.M = 1'b0;
        bus.ovf_clr = 1'b0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        check_sticky("reset");
        reset = 1'b0;

        // PC+4
        step("pc4",        64'h0, 64'h4, 1'b0, 1'b0);
        // 5-7 borrows, 7-5 does not
        step("sub_neg",    64'h5, 64'h7, 1'b1, 1'b0);
        step("sub_pos",    64'h7, 64'h5, 1'b1, 1'b0);
        // wrap-around
        step("wrap",       64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        // signed overflow, sticky then persists after ovf drops
        step("ovf_add",    64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        step("ovf_gone",   64'h1, 64'h1, 1'b0, 1'b0);
        step("ovf_hold",   64'h2, 64'h3, 1'b0, 1'b0);
        // clear with overflow present at the output: clear wins
        step("ovf_set",    64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
        step("ovf_clr",    64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1);
        step("after_clr",  64'h10, 64'h10, 1'b1, 1'b0);
        step("sub_self",   64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        step("sub_zero",   64'h0, 64'h0, 1'b1, 1'b0);

        // reset pulse between clock edges clears sticky immediately
        step("pre_rst",    64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        step("pre_rst2",   64'h3, 64'h9, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        reset_model();
        check_outputs("mid_rst");
        check_sticky("mid_rst");
        #1;
        reset = 1'b0;
        @(negedge clk);

        // random operations with corner-biased operands
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                1: rb = 64'h8000_0000_0000_0000;
                2: rb = ~ra;
                3: rb = ra;
                default: ;
            endcase
            rm = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 9) == 0);
            step("rand", ra, rb, rm, rc);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
